serial_adder: RTL

- Bit-serial WIDTH-bit adder that sequences operands LSB-first through one 1-bit full-adder cell. The cell is instantiated as full_adder with ports a, b, cin, sum, carry.
- A carry flip-flop links successive bits.
- It is the control/datapath stage that directly feeds the full_adder cell and consumes its outputs. It trades area for WIDTH cycles of latency, for narrow datapaths elsewhere in the design.

---
 rtl/serial_adder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands stream LSB-first through one full_adder cell.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b ^ cin;
   assign carry = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // Only the upper WIDTH-1 result bits need storage; the last bit comes straight from the cell.
   logic [WIDTH-2:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic [WIDTH-1:0] res_next;
   logic             fa_sum, fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   full_adder u_fa (
      .a     (sa_q[0]),
      .b     (sb_q[0]),
      .cin   (carry_q),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   assign res_next = {fa_sum, res_q};

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               sa_d    = a;
               sb_d    = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            res_d   = res_next[WIDTH-1:1];
            carry_d = fa_carry;
            sa_d    = sa_q >> 1;
            sb_d    = sb_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               sum_d   = res_next;
               cout_d  = fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
               // carry_q is the carry into the MSB on the final bit.
               ovf_d   = carry_q ^ fa_carry;
`endif
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule
